// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, opcodes,
// next-PC / ALU / extender selects, exception codes and instruction classes.
package mips_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_EXC    = 3'd6
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_COP0  = 6'h10;

    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_ERET  = 6'h18;

    localparam logic [2:0] PCI_SEQ  = 3'b000;
    localparam logic [2:0] PCI_BR   = 3'b001;
    localparam logic [2:0] PCI_JMP  = 3'b010;
    localparam logic [2:0] PCI_EPC  = 3'b011;
    localparam logic [2:0] PCI_EXC  = 3'b100;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_OR   = 2'b10;
    localparam logic [1:0] ALU_LUI  = 2'b11;

    localparam logic [1:0] EXT_ZERO  = 2'b00;
    localparam logic [1:0] EXT_SIGN  = 2'b01;
    localparam logic [1:0] EXT_UPPER = 2'b10;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_IBE  = 5'd6;
    localparam logic [4:0] EXC_DBE  = 5'd7;
    localparam logic [4:0] EXC_RI   = 5'd10;

    typedef enum logic [3:0] {
        IC_ADDU    = 4'd0,
        IC_SUBU    = 4'd1,
        IC_ORI     = 4'd2,
        IC_LUI     = 4'd3,
        IC_LW      = 4'd4,
        IC_SW      = 4'd5,
        IC_BEQ     = 4'd6,
        IC_J       = 4'd7,
        IC_ERET    = 4'd8,
        IC_ILLEGAL = 4'd9
    } iclass_t;

    function automatic logic is_rtype(input iclass_t c);
        return (c == IC_ADDU) || (c == IC_SUBU);
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Bundle between mc_ctrl and the IM/DM, datapath and CP0.
// master = control unit, slave = the surrounding core.
interface mc_ctrl_if #(parameter int IRQ_LINES = 6) ();
    logic [31:0]          od;
    logic                 mem_rdy;
    logic                 zero;
    logic [IRQ_LINES-1:0] irq;
    logic [IRQ_LINES-1:0] im;
    logic                 ie;
    logic                 exl;
    logic [2:0]           state;
    logic                 mem_req;
    logic                 ir_w;
    logic                 pc_w;
    logic [2:0]           pci;
    logic [1:0]           alu_op;
    logic                 alu_b_imm;
    logic [1:0]           ext_op;
    logic                 reg_w;
    logic                 reg_dst;
    logic                 mem_to_reg;
    logic                 dm_w;
    logic                 cp0_w;
    logic                 cp0_epc;
    logic [4:0]           exc_code;
    logic [IRQ_LINES-1:0] int_pend;

    modport master (
        input  od, mem_rdy, zero, irq, im, ie, exl,
        output state, mem_req, ir_w, pc_w, pci, alu_op, alu_b_imm, ext_op,
               reg_w, reg_dst, mem_to_reg, dm_w, cp0_w, cp0_epc, exc_code, int_pend
    );

    modport slave (
        output od, mem_rdy, zero, irq, im, ie, exl,
        input  state, mem_req, ir_w, pc_w, pci, alu_op, alu_b_imm, ext_op,
               reg_w, reg_dst, mem_to_reg, dm_w, cp0_w, cp0_epc, exc_code, int_pend
    );
endinterface

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct fields of the IR to
// an instruction class; anything outside the supported set is illegal.
module mc_decode
    import mips_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output iclass_t    iclass,
    output logic       legal
);

    // Opcode/funct lookup
    always_comb begin
        iclass = IC_ILLEGAL;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: iclass = IC_ADDU;
                    FN_SUBU: iclass = IC_SUBU;
                    default: iclass = IC_ILLEGAL;
                endcase
            end
            OP_ORI:  iclass = IC_ORI;
            OP_LUI:  iclass = IC_LUI;
            OP_LW:   iclass = IC_LW;
            OP_SW:   iclass = IC_SW;
            OP_BEQ:  iclass = IC_BEQ;
            OP_J:    iclass = IC_J;
            OP_COP0: begin
                if (funct == FN_ERET) begin
                    iclass = IC_ERET;
                end else begin
                    iclass = IC_ILLEGAL;
                end
            end
            default: iclass = IC_ILLEGAL;
        endcase
    end

    assign legal = (iclass != IC_ILLEGAL);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main control FSM with memory-wait timeout and exception entry.
// Interrupt front-end is built only when MC_CTRL_IRQ_EN is defined.
module mc_ctrl
    import mips_pkg::*;
#(
    parameter int IRQ_LINES   = 6,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    mc_ctrl_if.master bus
);

    localparam bit TMO_EN = (MEM_TIMEOUT > 0);
    localparam int CNT_W  = TMO_EN ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_EN ? MEM_TIMEOUT - 1 : 0);

    state_t           state_r, state_s;
    logic [31:0]      ir_r;
    logic [CNT_W-1:0] cnt_r;
    logic [4:0]       exc_code_r, exc_code_s;
    iclass_t          iclass_s;
    logic             legal_s;
    logic             int_take_s;
    logic             mem_phase_s;
    logic             tmo_s;
    logic             unused_ir_s;

    mc_decode u_decode (
        .op     (ir_r[31:26]),
        .funct  (ir_r[5:0]),
        .iclass (iclass_s),
        .legal  (legal_s)
    );

    // Register and immediate fields are consumed by the datapath, not here.
    assign unused_ir_s = ^ir_r[25:6];

`ifdef MC_CTRL_IRQ_EN
    logic [IRQ_LINES-1:0] int_pend_r;

    assign int_take_s = (|(bus.irq & bus.im)) & bus.ie & ~bus.exl;

    // Snapshot of the pending lines that caused the interrupt entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_pend_r <= {IRQ_LINES{1'b0}};
        end else if ((state_r == ST_DECODE) && int_take_s) begin
            int_pend_r <= bus.irq & bus.im;
        end else begin
            int_pend_r <= int_pend_r;
        end
    end

    assign bus.int_pend = int_pend_r;
`else
    logic unused_irq_s;

    assign int_take_s   = 1'b0;
    assign bus.int_pend = {IRQ_LINES{1'b0}};
    assign unused_irq_s = ^{bus.irq, bus.im, bus.ie, bus.exl};
`endif

    assign mem_phase_s = (state_r == ST_FETCH) || (state_r == ST_MEM);
    // mem_rdy in the last allowed wait cycle still completes the access.
    assign tmo_s       = TMO_EN && (cnt_r == CNT_LAST) && !bus.mem_rdy;

    // Next-state and exception-cause selection
    always_comb begin
        state_s    = state_r;
        exc_code_s = exc_code_r;
        case (state_r)
            ST_IDLE: state_s = ST_FETCH;
            ST_FETCH: begin
                if (bus.mem_rdy) begin
                    state_s = ST_DECODE;
                end else if (tmo_s) begin
                    state_s    = ST_EXC;
                    exc_code_s = EXC_IBE;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (int_take_s) begin
                    state_s    = ST_EXC;
                    exc_code_s = EXC_INT;
                end else if (!legal_s) begin
                    state_s    = ST_EXC;
                    exc_code_s = EXC_RI;
                end else begin
                    state_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (iclass_s)
                    IC_LW, IC_SW:          state_s = ST_MEM;
                    IC_BEQ, IC_J, IC_ERET: state_s = ST_FETCH;
                    default:               state_s = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (bus.mem_rdy) begin
                    state_s = (iclass_s == IC_LW) ? ST_WB : ST_FETCH;
                end else if (tmo_s) begin
                    state_s    = ST_EXC;
                    exc_code_s = EXC_DBE;
                end else begin
                    state_s = ST_MEM;
                end
            end
            ST_WB:   state_s = ST_FETCH;
            ST_EXC:  state_s = ST_FETCH;
            default: state_s = ST_IDLE;
        endcase
    end

    // State, IR, wait counter and cause register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            ir_r       <= 32'h0000_0000;
            cnt_r      <= {CNT_W{1'b0}};
            exc_code_r <= 5'd0;
        end else begin
            state_r    <= state_s;
            exc_code_r <= exc_code_s;
            if ((state_r == ST_FETCH) && bus.mem_rdy) begin
                ir_r <= bus.od;
            end else begin
                ir_r <= ir_r;
            end
            if (mem_phase_s && !bus.mem_rdy && !tmo_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= {CNT_W{1'b0}};
            end
        end
    end

    assign bus.state    = state_r;
    assign bus.exc_code = exc_code_r;

    // Control outputs decoded from state and IR class
    always_comb begin
        bus.mem_req    = 1'b0;
        bus.ir_w       = 1'b0;
        bus.pc_w       = 1'b0;
        bus.pci        = PCI_SEQ;
        bus.alu_op     = ALU_ADD;
        bus.alu_b_imm  = 1'b0;
        bus.ext_op     = EXT_ZERO;
        bus.reg_w      = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.dm_w       = 1'b0;
        bus.cp0_w      = 1'b0;
        bus.cp0_epc    = 1'b0;
        case (state_r)
            ST_FETCH: begin
                bus.mem_req = 1'b1;
                bus.ir_w    = bus.mem_rdy;
                bus.pc_w    = bus.mem_rdy;
            end
            ST_EXEC: begin
                case (iclass_s)
                    IC_SUBU: bus.alu_op = ALU_SUB;
                    IC_ORI: begin
                        bus.alu_op    = ALU_OR;
                        bus.alu_b_imm = 1'b1;
                    end
                    IC_LUI: begin
                        bus.alu_op    = ALU_LUI;
                        bus.alu_b_imm = 1'b1;
                        bus.ext_op    = EXT_UPPER;
                    end
                    IC_LW, IC_SW: begin
                        bus.alu_b_imm = 1'b1;
                        bus.ext_op    = EXT_SIGN;
                    end
                    IC_BEQ: begin
                        bus.alu_op = ALU_SUB;
                        bus.pc_w   = bus.zero;
                        bus.pci    = PCI_BR;
                    end
                    IC_J: begin
                        bus.pc_w = 1'b1;
                        bus.pci  = PCI_JMP;
                    end
                    IC_ERET: begin
                        bus.pc_w = 1'b1;
                        bus.pci  = PCI_EPC;
                    end
                    default: bus.alu_op = ALU_ADD;
                endcase
            end
            ST_MEM: begin
                bus.mem_req = 1'b1;
                bus.dm_w    = bus.mem_rdy && (iclass_s == IC_SW);
            end
            ST_WB: begin
                bus.reg_w      = 1'b1;
                bus.reg_dst    = is_rtype(iclass_s);
                bus.mem_to_reg = (iclass_s == IC_LW);
            end
            ST_EXC: begin
                bus.cp0_w   = 1'b1;
                bus.cp0_epc = 1'b1;
                bus.pc_w    = 1'b1;
                bus.pci     = PCI_EXC;
            end
            default: bus.mem_req = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-cycle comparison of every output
// against a queue of expected cycles built from the instruction-level rules.
module tb_mc_ctrl;

    localparam int IRQ_LINES = 6;
    localparam int TMO       = 4;
`ifdef MC_CTRL_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                           S_MEM = 3'd4, S_WB = 3'd5, S_EXC = 3'd6;

    typedef struct packed {
        logic [2:0]           state;
        logic                 mem_req;
        logic                 ir_w;
        logic                 pc_w;
        logic [2:0]           pci;
        logic [1:0]           alu_op;
        logic                 alu_b_imm;
        logic [1:0]           ext_op;
        logic                 reg_w;
        logic                 reg_dst;
        logic                 mem_to_reg;
        logic                 dm_w;
        logic                 cp0_w;
        logic                 cp0_epc;
        logic [4:0]           exc_code;
        logic [IRQ_LINES-1:0] int_pend;
    } outs_t;

    typedef struct packed {
        logic  rdy;
        outs_t o;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    rec_t exp_q[$];
    logic [4:0]           exp_code;
    logic [IRQ_LINES-1:0] exp_pend;
    outs_t obs;

    mc_ctrl_if #(.IRQ_LINES(IRQ_LINES)) bus ();

    mc_ctrl #(.IRQ_LINES(IRQ_LINES), .MEM_TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign obs = {bus.state, bus.mem_req, bus.ir_w, bus.pc_w, bus.pci, bus.alu_op, bus.alu_b_imm,
                  bus.ext_op, bus.reg_w, bus.reg_dst, bus.mem_to_reg, bus.dm_w, bus.cp0_w,
                  bus.cp0_epc, bus.exc_code, bus.int_pend};

    // Instruction class from the legal-instruction list; -1 means reserved.
    function automatic int kind(input logic [31:0] w);
        logic [5:0] op, fn;
        op = w[31:26];
        fn = w[5:0];
        if (op == 6'h00 && fn == 6'h21) return 0;
        if (op == 6'h00 && fn == 6'h23) return 1;
        if (op == 6'h0d) return 2;
        if (op == 6'h0f) return 3;
        if (op == 6'h23) return 4;
        if (op == 6'h2b) return 5;
        if (op == 6'h04) return 6;
        if (op == 6'h02) return 7;
        if (op == 6'h10 && fn == 6'h18) return 8;
        return -1;
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic outs_t blank(input logic [2:0] st);
        outs_t o;
        o          = '0;
        o.state    = st;
        o.exc_code = exp_code;
        o.int_pend = exp_pend;
        return o;
    endfunction

    function automatic outs_t exc_rec();
        outs_t o;
        o         = blank(S_EXC);
        o.cp0_w   = 1'b1;
        o.cp0_epc = 1'b1;
        o.pc_w    = 1'b1;
        o.pci     = 3'b100;
        return o;
    endfunction

    task automatic push(input logic rdy, input outs_t o);
        exp_q.push_back({rdy, o});
    endtask

    // Expected cycle sequence for one instruction starting in FETCH.
    task automatic build(input logic [31:0] w, input int fw, input int mw);
        outs_t o;
        int    k;
        logic  intr;
        k = kind(w);
        o = blank(S_FETCH);
        o.mem_req = 1'b1;
        if (fw >= TMO) begin
            for (int i = 0; i < TMO; i++) push(1'b0, o);
            exp_code = 5'd6;
            push(rnd_bit(), exc_rec());
            return;
        end
        for (int i = 0; i < fw; i++) push(1'b0, o);
        o.ir_w = 1'b1;
        o.pc_w = 1'b1;
        push(1'b1, o);
        push(rnd_bit(), blank(S_DECODE));
        intr = IRQ_EN && (|(bus.irq & bus.im)) && bus.ie && !bus.exl;
        if (intr) begin
            exp_pend = bus.irq & bus.im;
            exp_code = 5'd0;
            push(rnd_bit(), exc_rec());
            return;
        end
        if (k < 0) begin
            exp_code = 5'd10;
            push(rnd_bit(), exc_rec());
            return;
        end
        o = blank(S_EXEC);
        case (k)
            1: o.alu_op = 2'b01;
            2: begin o.alu_op = 2'b10; o.alu_b_imm = 1'b1; end
            3: begin o.alu_op = 2'b11; o.alu_b_imm = 1'b1; o.ext_op = 2'b10; end
            4, 5: begin o.alu_b_imm = 1'b1; o.ext_op = 2'b01; end
            6: begin o.alu_op = 2'b01; o.pc_w = bus.zero; o.pci = 3'b001; end
            7: begin o.pc_w = 1'b1; o.pci = 3'b010; end
            8: begin o.pc_w = 1'b1; o.pci = 3'b011; end
            default: o.alu_op = 2'b00;
        endcase
        push(rnd_bit(), o);
        if (k == 4 || k == 5) begin
            o = blank(S_MEM);
            o.mem_req = 1'b1;
            if (mw >= TMO) begin
                for (int i = 0; i < TMO; i++) push(1'b0, o);
                exp_code = 5'd7;
                push(rnd_bit(), exc_rec());
                return;
            end
            for (int i = 0; i < mw; i++) push(1'b0, o);
            o.dm_w = (k == 5);
            push(1'b1, o);
        end
        if (k <= 4) begin
            o = blank(S_WB);
            o.reg_w      = 1'b1;
            o.reg_dst    = (k <= 1);
            o.mem_to_reg = (k == 4);
            push(rnd_bit(), o);
        end
    endtask

    // Replay the expected queue: drive mem_rdy, compare on the falling edge.
    task automatic run_q(input string tag);
        rec_t r;
        while (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            bus.mem_rdy = r.rdy;
            @(negedge clk);
            checks++;
            assert (obs === r.o) else begin
                errors++;
                $error("FAIL %s cyc=%0d state=%0d observed=%h expected=%h", tag, cyc, obs.state, obs, r.o);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_instr(input string tag, input logic [31:0] w, input int fw, input int mw,
                            input logic z);
        bus.od   = w;
        bus.zero = z;
        build(w, fw, mw);
        run_q(tag);
    endtask

    task automatic check_reset(input string tag);
        exp_code = 5'd0;
        exp_pend = '0;
        checks++;
        assert (obs === blank(S_IDLE)) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, blank(S_IDLE));
        end
    endtask

    initial begin
        logic [31:0] w, rnd;
        int          r, fw, mw;
        rst_n       = 1'b0;
        bus.od      = 32'h0000_0000;
        bus.mem_rdy = 1'b0;
        bus.zero    = 1'b0;
        bus.irq     = '0;
        bus.im      = '0;
        bus.ie      = 1'b0;
        bus.exl     = 1'b0;
        exp_code    = 5'd0;
        exp_pend    = '0;
        #3;
        check_reset("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push(rnd_bit(), blank(S_IDLE));
        run_q("idle");

        do_instr("addu",        32'h0022_8021, 0, 0, 1'b0);
        do_instr("lw_wait2",    32'h8c33_0002, 0, 2, 1'b0);
        do_instr("beq_taken",   32'h1021_0004, 0, 0, 1'b1);
        do_instr("beq_not",     32'h1021_0004, 0, 0, 1'b0);
        do_instr("ri",          32'hffff_ffff, 0, 0, 1'b0);
        bus.irq = 6'b000100;
        bus.im  = 6'b111111;
        bus.ie  = 1'b1;
        bus.exl = 1'b0;
        do_instr("irq_ori",     32'h3432_0080, 0, 0, 1'b0);
        bus.irq = '0;
        do_instr("fetch_tmo",   32'h3432_0080, 4, 0, 1'b0);
        do_instr("fetch_rdy4",  32'h3432_0080, 3, 0, 1'b0);
        do_instr("mem_tmo",     32'h8c33_0002, 0, 4, 1'b0);
        do_instr("mem_rdy4",    32'hac33_0010, 1, 3, 1'b0);
        do_instr("j",           32'h0800_0040, 0, 0, 1'b0);
        do_instr("eret",        32'h4200_0018, 0, 0, 1'b0);
        do_instr("subu",        32'h0022_8023, 2, 0, 1'b0);
        do_instr("lui",         32'h3c01_1234, 0, 0, 1'b0);

        for (int n = 0; n < 200; n++) begin
            rnd = $urandom;
            case ($urandom_range(0, 9))
                0: w = {6'h00, rnd[25:6], 6'h21};
                1: w = {6'h00, rnd[25:6], 6'h23};
                2: w = {6'h0d, rnd[25:0]};
                3: w = {6'h0f, rnd[25:0]};
                4: w = {6'h23, rnd[25:0]};
                5: w = {6'h2b, rnd[25:0]};
                6: w = {6'h04, rnd[25:0]};
                7: w = {6'h02, rnd[25:0]};
                8: w = {6'h10, rnd[25:6], 6'h18};
                default: w = rnd;
            endcase
            r  = $urandom_range(0, 9);
            fw = (r < 6) ? 0 : r - 5;
            r  = $urandom_range(0, 9);
            mw = (r < 6) ? 0 : r - 5;
            bus.irq = ($urandom_range(0, 3) == 0) ? IRQ_LINES'($urandom) : '0;
            bus.im  = IRQ_LINES'($urandom);
            bus.ie  = rnd_bit();
            bus.exl = rnd_bit();
            do_instr("random", w, fw, mw, rnd_bit());
        end

        // Reset while a fetch is waiting; cause register must clear too.
        bus.irq = '0;
        do_instr("ri_pre_rst", 32'hffff_ffff, 0, 0, 1'b0);
        bus.mem_rdy = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push(rnd_bit(), blank(S_IDLE));
        run_q("idle2");
        do_instr("lw_post_rst", 32'h8c33_0002, 0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
